// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed-latency response, byte/half/word access.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W instead of force-aligning.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_bhw,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            lat_we;
   logic [2:0]      lat_bhw;
   logic [AW+1:0]   lat_addr;
   logic [31:0]     lat_wdata;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            accept, do_access;
   logic            a_we;
   logic [2:0]      a_bhw;
   logic [AW+1:0]   a_addr;
   logic [31:0]     a_wdata;
   logic            a_illegal, a_misalign, a_err;
   logic [3:0]      wmask;
   logic [31:0]     wword, rword, ld_data;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic            unused_addr;

   assign accept      = req_valid & req_ready;
   assign unused_addr = ^req_addr[31:AW+2];

   // With a single-cycle latency the access happens on the accept edge, so use the live request.
   assign a_we    = (LATENCY == 1) ? req_we              : lat_we;
   assign a_bhw   = (LATENCY == 1) ? req_bhw             : lat_bhw;
   assign a_addr  = (LATENCY == 1) ? req_addr[AW+1:0]    : lat_addr;
   assign a_wdata = (LATENCY == 1) ? req_wdata           : lat_wdata;

   assign do_access = rstn & (((state == S_WAIT) && (cnt == CW'(1))) ||
                              ((LATENCY == 1) && accept));

   always_comb begin
      a_illegal = (a_bhw[1:0] == 2'b11) | (a_bhw[2] & a_bhw[1]);
`ifdef DMEM_MISALIGN_TRAP_EN
      a_misalign = ((a_bhw[1:0] == 2'b01) && a_addr[0]) ||
                   ((a_bhw[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
      a_misalign = 1'b0;
`endif
      a_err = a_illegal | a_misalign;
   end

   // Store lanes: bhw[2] is ignored, so BU/HU stores behave as B/H.
   always_comb begin
      case (a_bhw[1:0])
         2'b00: begin
            wmask = 4'b0001 << a_addr[1:0];
            wword = {4{a_wdata[7:0]}};
         end
         2'b01: begin
            wmask = a_addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{a_wdata[15:0]}};
         end
         default: begin
            wmask = 4'b1111;
            wword = a_wdata;
         end
      endcase
   end

   always_comb begin
      rword   = mem[a_addr[AW+1:2]];
      ld_byte = 8'(rword >> {a_addr[1:0], 3'b000});
      ld_half = a_addr[1] ? rword[31:16] : rword[15:0];
      case (a_bhw)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = rword;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_access && a_we && !a_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[a_addr[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         lat_we     <= 1'b0;
         lat_bhw    <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            lat_we    <= req_we;
            lat_bhw   <= req_bhw;
            lat_addr  <= req_addr[AW+1:0];
            lat_wdata <= req_wdata;
            cnt       <= CW'(LATENCY - 1);
         end
         case (state)
            S_IDLE, S_RESP: begin
               if (accept && LATENCY == 1) begin
                  state     <= S_RESP;
                  req_ready <= 1'b1;
               end else if (accept) begin
                  state     <= S_WAIT;
                  req_ready <= 1'b0;
               end else begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
               end
            end
            S_WAIT: begin
               // The edge that counts down to zero is the RESP-entry edge.
               if (cnt == CW'(1)) begin
                  state     <= S_RESP;
                  req_ready <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
         if (do_access) begin
            resp_valid <= 1'b1;
            resp_rdata <= (a_we || a_err) ? 32'h0 : ld_data;
            resp_err   <= a_err;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard of expected responses, checked as they emerge.
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_bhw = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cycle = 0;
   int   last_acc = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_bhw(req_bhw), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_chk++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   // Responses are checked at the falling edge; the edge that samples them is cycle+1.
   always @(negedge clk) begin
      if (resp_valid) begin
         if (q.size() == 0) begin
            check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
            check("resp_latency", cycle + 1, e.acc + LAT);
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                        input bit push);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_bhw   = bhw;
      req_addr  = addr;
      req_wdata = wdata;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
      if (push) q.push_back('{erd, eerr, cycle + 1});
      last_acc = cycle + 1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int a0, a1, a2;
      logic [31:0] w10;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", {31'h0, resp_err}, 32'h0);
      rstn = 1'b1;
      @(negedge clk);

      // word store / load
      issue(1'b1, 3'b010, 32'h10, 32'h8000_00F1, 32'h0, 1'b0, 1'b1);
      drain();
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00F1, 1'b0, 1'b1);
      drain();

      // byte stores and extension
      issue(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 3'b000, 32'h13, 32'h1234_567F, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b000, 32'h13, 32'h0, 32'h0000_007F, 1'b0, 1'b1);
      issue(1'b1, 3'b000, 32'h11, 32'hABCD_EFF0, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h7F00_F000, 1'b0, 1'b1);
      issue(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b1);
      issue(1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_00F0, 1'b0, 1'b1);
      drain();

      // halfword
      issue(1'b1, 3'b010, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 3'b001, 32'h22, 32'h5555_BEEF, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0, 1'b1);
      issue(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_5678, 1'b0, 1'b1);
      drain();

      // back-to-back with address wrap; load in the store's RESP cycle sees new data
      issue(1'b1, 3'b010, 32'(4 * DEPTH + 32'h10), 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
      a0 = last_acc;
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      a1 = last_acc;
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_5678, 1'b0, 1'b1);
      a2 = last_acc;
      check("b2b_gap1", 32'(a1 - a0), 32'd2);
      check("b2b_gap2", 32'(a2 - a1), 32'd2);
      drain();

      // misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
      issue(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(1'b1, 3'b001, 32'h11, 32'h0000_1111, 32'h0, 1'b1, 1'b1);
      issue(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
      w10 = 32'hCAFE_F00D;
`else
      issue(1'b0, 3'b010, 32'h12, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      issue(1'b1, 3'b001, 32'h11, 32'h0000_1111, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFF_CAFE, 1'b0, 1'b1);
      w10 = 32'hCAFE_1111;
`endif
      issue(1'b0, 3'b010, 32'h10, 32'h0, w10, 1'b0, 1'b1);
      drain();

      // illegal size codes: no write, error response
      issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(1'b1, 3'b110, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
      drain();
      check("hold_resp_err", {31'h0, resp_err}, 32'h1);
      issue(1'b0, 3'b010, 32'h10, 32'h0, w10, 1'b0, 1'b1);
      drain();

      // reset one cycle after accepting a store drops it
      issue(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
      drain();
      issue(1'b1, 3'b010, 32'h40, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
      rstn = 1'b0;
      #1;
      check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
      check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
